// File: rtl/vi_rtc_pkg.sv
// Shared constants and helpers for the vectored-interrupt controller / RTC.
// lowest_set returns {valid, index} for the highest-priority (lowest) set bit.
package vi_rtc_pkg;
  localparam logic VI_REG_MASK = 1'b0;
  localparam logic VI_REG_CMD  = 1'b1;
  localparam int   CMD_EOI     = 7;
  localparam int   CMD_RTC_EN  = 6;

  function automatic logic [7:0] rst_opcode(input logic [2:0] level);
    return {2'b11, level, 3'b111};
  endfunction

  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction
endpackage

// File: rtl/vi_rtc_divider.sv
// RTC timebase: a prescaler over ce pulses feeding a selectable decade divider.
// Both counters sit at zero whenever the clock is disabled or being cleared.
module rtc_divider #(
  parameter int TICK_DIV = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       en,
  input  logic [1:0] rate,
  output logic       tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    div_q, div_d;
  logic [9:0]    div_max;
  logic          base_tick;

  always_comb begin
    case (rate)
      2'd0:    div_max = 10'd0;
      2'd1:    div_max = 10'd9;
      2'd2:    div_max = 10'd99;
      default: div_max = 10'd999;
    endcase
  end

  assign base_tick = en & ce & (presc_q == PW'(TICK_DIV - 1));
  assign tick      = base_tick & (div_q == div_max) & ~reset;

  always_comb begin
    presc_d = presc_q;
    div_d   = div_q;
    if (ce) presc_d = base_tick ? '0 : presc_q + 1'b1;
    if (base_tick) div_d = (div_q == div_max) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      presc_q <= '0;
      div_q   <= '0;
    end else begin
      presc_q <= presc_d;
      div_q   <= div_d;
    end
  end
endmodule

// File: rtl/vi_rtc.sv
// 8-level vectored interrupt controller with an RTC tick on one level.
// rd/we/inta are single-clock strobes; their result lands in data_out one clock later.
module vi_rtc
  import vi_rtc_pkg::*;
#(
  parameter int TICK_DIV  = 25000,
  parameter int RTC_LEVEL = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       addr,
  input  logic [7:0] data_in,
  input  logic       rd,
  input  logic       we,
  input  logic       inta,
  input  logic [7:0] irq_in,
  output logic       intr,
  output logic [7:0] data_out
);
  logic [7:0] mask_q, mask_d, pend_q, pend_d, isr_q, isr_d, irq_q;
  logic [7:0] data_q, data_d;
  logic       rtc_en_q, rtc_en_d, intr_q, intr_d;
  logic [1:0] rate_q, rate_d;
  logic [7:0] set_vec, pend_clr, isr_set, isr_clr;
  logic [3:0] win, isr_low, next_win, next_isr;
  logic       cmd_wr, tick;
  logic       unused_cmd_bits;

  assign unused_cmd_bits = ^data_in[5:2];

  rtc_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset | cmd_wr),
    .ce    (ce),
    .en    (rtc_en_q),
    .rate  (rate_q),
    .tick  (tick)
  );

  assign win     = lowest_set(pend_q & mask_q);
  assign isr_low = lowest_set(isr_q);

  always_comb begin
    set_vec            = irq_in & ~irq_q;
    set_vec[RTC_LEVEL] = tick;
    pend_clr = '0;
    isr_set  = '0;
    isr_clr  = '0;
    data_d   = data_q;
    mask_d   = mask_q;
    rtc_en_d = rtc_en_q;
    rate_d   = rate_q;
    cmd_wr   = 1'b0;
    if (inta) begin
      if (win[3]) begin
        pend_clr[win[2:0]] = 1'b1;
        isr_set[win[2:0]]  = 1'b1;
        data_d             = rst_opcode(win[2:0]);
      end else begin
        data_d = 8'hFF;
      end
    end else if (rd) begin
      data_d = (addr == VI_REG_CMD) ? isr_q : pend_q;
    end
    if (we) begin
      if (addr == VI_REG_MASK) begin
        mask_d = data_in;
      end else begin
        cmd_wr = 1'b1;
        if (data_in[CMD_EOI] && isr_low[3]) isr_clr[isr_low[2:0]] = 1'b1;
        rtc_en_d = data_in[CMD_RTC_EN];
        rate_d   = data_in[1:0];
      end
    end
    // A new edge beats a same-cycle clear, so set is OR'd in last.
    pend_d   = (pend_q & ~pend_clr) | set_vec;
    isr_d    = (isr_q & ~isr_clr) | isr_set;
    next_win = lowest_set(pend_d & mask_d);
    next_isr = lowest_set(isr_d);
    intr_d   = next_win[3] && (!next_isr[3] || (next_win[2:0] < next_isr[2:0]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= '0;
      pend_q   <= '0;
      isr_q    <= '0;
      irq_q    <= '0;
      data_q   <= '0;
      rtc_en_q <= 1'b0;
      rate_q   <= '0;
      intr_q   <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      isr_q    <= isr_d;
      irq_q    <= irq_in;
      data_q   <= data_d;
      rtc_en_q <= rtc_en_d;
      rate_q   <= rate_d;
      intr_q   <= intr_d;
    end
  end

  assign intr     = intr_q;
  assign data_out = data_q;
endmodule
